// File: rtl/wall_probe_scheduler.sv
// Time-multiplexed wall-collision checker: snapshots every sprite on start, probes two
// leading-edge points per sprite through one shared map ROM port, publishes all results at once.
module wall_probe_scheduler #(
  parameter int N_CH      = 4,
  parameter int COORD_W   = 9,
  parameter int PIX_W     = 3,
  parameter int STEP      = 13,
  parameter int HALF_W    = 6,
  parameter int ROM_LAT   = 1,
  parameter int WALL_CODE = 0,
  parameter int MAP_W     = 320,
  parameter int MAP_H     = 240
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*N_CH-1:0]       dir,
  input  logic [COORD_W*N_CH-1:0] pos_x,
  input  logic [COORD_W*N_CH-1:0] pos_y,
  output logic [COORD_W-1:0]      rom_x,
  output logic [COORD_W-1:0]      rom_y,
  input  logic [PIX_W-1:0]        rom_pixel,
  output logic                    busy,
  output logic                    done,
  output logic [N_CH-1:0]         collide
);

  localparam int SW    = COORD_W + 2;
  localparam int NP    = 2 * N_CH;
  localparam int IDX_W = $clog2(NP);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
  localparam logic signed [SW-1:0] HALF_S = SW'(HALF_W);
  localparam logic signed [SW-1:0] MAPW_S = SW'(MAP_W);
  localparam logic signed [SW-1:0] MAPH_S = SW'(MAP_H);
  localparam logic signed [SW-1:0] ZERO_S = {SW{1'b0}};
  localparam logic [PIX_W-1:0]     WALL_PIX = PIX_W'(WALL_CODE);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NP - 1);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                    state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [4*N_CH-1:0]         dir_r;
  logic [COORD_W*N_CH-1:0]   pos_x_r;
  logic [COORD_W*N_CH-1:0]   pos_y_r;
  logic [N_CH-1:0]           shadow_r;
  logic                      acc_r;

  logic [CH_W-1:0]           ch_s;
  logic                      side_s;
  logic [3:0]                cd_s;
  logic signed [SW-1:0]      cx_s, cy_s, px_s, py_s, perp_s;
  logic                      dir_ok_s, oob_s, addr_ok_s, hit_s;
  logic [N_CH-1:0]           shadow_next_s;

  // Current probe geometry, bounds check, hit decision and shadow update for the active slot.
  always_comb begin
    ch_s     = CH_W'(idx_r >> 1);
    side_s   = idx_r[0];
    cd_s     = dir_r[ch_s*4 +: 4];
    cx_s     = $signed({2'b00, pos_x_r[ch_s*COORD_W +: COORD_W]});
    cy_s     = $signed({2'b00, pos_y_r[ch_s*COORD_W +: COORD_W]});
    perp_s   = side_s ? HALF_S : -HALF_S;
    dir_ok_s = 1'b1;
    px_s     = ZERO_S;
    py_s     = ZERO_S;
    case (cd_s)
      4'b1000: begin px_s = cx_s - STEP_S; py_s = cy_s + perp_s; end
      4'b0010: begin px_s = cx_s + STEP_S; py_s = cy_s + perp_s; end
      4'b0100: begin px_s = cx_s + perp_s; py_s = cy_s - STEP_S; end
      4'b0001: begin px_s = cx_s + perp_s; py_s = cy_s + STEP_S; end
      default: begin dir_ok_s = 1'b0; px_s = ZERO_S; py_s = ZERO_S; end
    endcase
    oob_s     = (px_s < ZERO_S) || (px_s >= MAPW_S) || (py_s < ZERO_S) || (py_s >= MAPH_S);
    addr_ok_s = dir_ok_s && !oob_s;
    // A malformed direction never reports a hit, even when its probe would land off-map.
    hit_s     = dir_ok_s && (oob_s || (rom_pixel == WALL_PIX));
    shadow_next_s = shadow_r;
    if (side_s) begin
      shadow_next_s[ch_s] = acc_r | hit_s;
    end else begin
      shadow_next_s = shadow_r;
    end
  end

  // Scan sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {IDX_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      dir_r    <= {(4*N_CH){1'b0}};
      pos_x_r  <= {(COORD_W*N_CH){1'b0}};
      pos_y_r  <= {(COORD_W*N_CH){1'b0}};
      shadow_r <= {N_CH{1'b0}};
      acc_r    <= 1'b0;
      rom_x    <= {COORD_W{1'b0}};
      rom_y    <= {COORD_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      collide  <= {N_CH{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            dir_r    <= dir;
            pos_x_r  <= pos_x;
            pos_y_r  <= pos_y;
            idx_r    <= {IDX_W{1'b0}};
            shadow_r <= {N_CH{1'b0}};
            acc_r    <= 1'b0;
            busy     <= 1'b1;
            state_r  <= ISSUE;
          end else begin
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          if (addr_ok_s) begin
            rom_x <= px_s[COORD_W-1:0];
            rom_y <= py_s[COORD_W-1:0];
          end else begin
            rom_x <= {COORD_W{1'b0}};
            rom_y <= {COORD_W{1'b0}};
          end
          cnt_r   <= CNT_LOAD;
          state_r <= WAIT;
        end
        WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= SAMPLE;
          end else begin
            cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        SAMPLE: begin
          shadow_r <= shadow_next_s;
          acc_r    <= hit_s;
          if (idx_r == LAST_IDX) begin
            collide <= shadow_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= FINISH;
          end else begin
            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            state_r <= ISSUE;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wall_probe_scheduler.sv
// Scoreboard bench: two schedulers (ROM latency 1 and 3) share stimulus; each has its own
// latency-accurate ROM model and a monitor comparing busy/done/collide against a behavioural model.
module tb_wall_probe_scheduler;

  typedef struct {
    int         st;
    int         dn;
    logic [3:0] col;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dir;
  logic [35:0] pos_x, pos_y;
  logic [8:0]  rx [2];
  logic [8:0]  ry [2];
  logic [2:0]  pix [2];
  logic [2:0]  p3a, p3b;
  logic [1:0]  busy_v, done_v;
  logic [3:0]  col_v [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   map_mode = 0;
  int   salt = 0;
  int   lat [2] = '{24, 40};
  int   free_at [2] = '{0, 0};
  logic [3:0] held [2] = '{4'd0, 4'd0};
  exp_t q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wall_probe_scheduler #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .pos_x(pos_x), .pos_y(pos_y),
    .rom_x(rx[0]), .rom_y(ry[0]), .rom_pixel(pix[0]),
    .busy(busy_v[0]), .done(done_v[0]), .collide(col_v[0])
  );

  wall_probe_scheduler #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .pos_x(pos_x), .pos_y(pos_y),
    .rom_x(rx[1]), .rom_y(ry[1]), .rom_pixel(pix[1]),
    .busy(busy_v[1]), .done(done_v[1]), .collide(col_v[1])
  );

  function automatic logic [2:0] map_pixel(input int x, input int y);
    if (map_mode == 0) return (x == 113 && y == 94) ? 3'd0 : 3'd5;
    else if (((x * 7 + y * 11 + salt) % 6) == 0) return 3'd0;
    else return 3'(1 + ((x + y) % 7));
  endfunction

  // ROM models: one-stage and three-stage read pipelines.
  always @(posedge clk) begin
    pix[0] <= map_pixel(int'(rx[0]), int'(ry[0]));
    p3a    <= map_pixel(int'(rx[1]), int'(ry[1]));
    p3b    <= p3a;
    pix[1] <= p3b;
  end

  function automatic bit probe_hit(input int x, input int y);
    if (x < 0 || x >= 320 || y < 0 || y >= 240) return 1'b1;
    return map_pixel(x, y) == 3'd0;
  endfunction

  function automatic logic [3:0] model_collide();
    logic [3:0] res;
    res = 4'd0;
    for (int c = 0; c < 4; c++) begin
      int x;
      int y;
      x = int'(pos_x[9*c +: 9]);
      y = int'(pos_y[9*c +: 9]);
      case (dir[4*c +: 4])
        4'b1000: res[c] = probe_hit(x - 13, y - 6) || probe_hit(x - 13, y + 6);
        4'b0010: res[c] = probe_hit(x + 13, y - 6) || probe_hit(x + 13, y + 6);
        4'b0100: res[c] = probe_hit(x - 6, y - 13) || probe_hit(x + 6, y - 13);
        4'b0001: res[c] = probe_hit(x - 6, y + 13) || probe_hit(x + 6, y + 13);
        default: res[c] = 1'b0;
      endcase
    end
    return res;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: compares each DUT against the front of its scoreboard queue every cycle.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      bit b_exp;
      bit d_exp;
      b_exp = 1'b0;
      d_exp = 1'b0;
      if (q[k].size() > 0) begin
        b_exp = (cyc >= q[k][0].st) && (cyc < q[k][0].dn);
        d_exp = (cyc == q[k][0].dn);
        if (d_exp) held[k] = q[k][0].col;
      end
      chk($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(b_exp));
      chk($sformatf("done%0d", k), 32'(done_v[k]), 32'(d_exp));
      chk($sformatf("collide%0d", k), 32'(col_v[k]), 32'(held[k]));
      if (d_exp) void'(q[k].pop_front());
    end
  end

  task automatic randomize_inputs();
    for (int c = 0; c < 4; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) dir[4*c +: 4] = 4'b0001 << (r % 4);
      else dir[4*c +: 4] = 4'($urandom_range(0, 15));
      pos_x[9*c +: 9] = 9'($urandom_range(0, 340));
      pos_y[9*c +: 9] = 9'($urandom_range(0, 260));
    end
  endtask

  task automatic accept(input int e);
    for (int k = 0; k < 2; k++) begin
      if (e >= free_at[k]) begin
        exp_t t;
        t.st = e;
        t.dn = e + lat[k];
        t.col = model_collide();
        q[k].push_back(t);
        free_at[k] = e + lat[k] + 2;
      end
    end
  endtask

  task automatic step(input bit st, input bit rnd);
    @(negedge clk);
    if (rnd) randomize_inputs();
    start = st;
    if (st) accept(cyc + 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (q[0].size() > 0 || q[1].size() > 0); i++) step(1'b0, 1'b1);
  endtask

  initial begin
    int e;
    rst = 1'b1; start = 1'b0; dir = 16'd0; pos_x = 36'd0; pos_y = 36'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    free_at[0] = cyc + 1;
    free_at[1] = cyc + 1;
    repeat (100) step(1'b0, 1'b1);

    // Directed scan: right-moving hit, left off-map, zero and multi-bit directions.
    dir   = {4'b0110, 4'b0000, 4'b1000, 4'b0010};
    pos_x = {9'd200, 9'd150, 9'd5, 9'd100};
    pos_y = {9'd120, 9'd120, 9'd50, 9'd100};
    step(1'b1, 1'b0);
    e = cyc + 1;
    chk("directed_model", 32'(q[0][0].col), 32'd3);
    for (int i = 0; i < 30; i++) begin
      step((cyc + 1 == e + 5) || (cyc + 1 == e + 25) || (cyc + 1 == e + 26), 1'b1);
      if (cyc == e + 2) begin
        chk("rom_x1_ch0a", 32'(rx[0]), 32'd113); chk("rom_y1_ch0a", 32'(ry[0]), 32'd94);
        chk("rom_x3_ch0a", 32'(rx[1]), 32'd113); chk("rom_y3_ch0a", 32'(ry[1]), 32'd94);
      end
      if (cyc == e + 5) begin
        chk("rom_y1_ch0b", 32'(ry[0]), 32'd106);
      end
      if (cyc == e + 8 || cyc == e + 11) begin
        chk("rom_x1_ch1", 32'(rx[0]), 32'd0); chk("rom_y1_ch1", 32'(ry[0]), 32'd0);
      end
      if (cyc == e + 12 || cyc == e + 17) begin
        chk("rom_x3_ch1", 32'(rx[1]), 32'd0); chk("rom_y3_ch1", 32'(ry[1]), 32'd0);
      end
    end
    wait_idle();

    // Randomised scans against a hashed maze.
    map_mode = 1;
    salt = $urandom_range(0, 99);
    repeat (3000) step($urandom_range(0, 7) == 0, 1'b1);
    wait_idle();

    // Abort mid-scan, then confirm silence and a clean restart.
    step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    q[0].delete(); q[1].delete();
    held[0] = 4'd0; held[1] = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    free_at[0] = cyc + 1;
    free_at[1] = cyc + 1;
    repeat (60) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    wait_idle();
    repeat (5) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
